eth_tx_framer: RTL and testbench

Parametrised Ethernet transmit framer for the 125 MHz GMII/RGMII transmit path. On a start pulse it builds one complete frame: preamble and SFD, MAC header, 16-bit sequence number, a variable-length payload read from a dual-bank byte buffer, zero padding to the Ethernet minimum, and the FCS. It then enforces the inter-frame gap. It sits between the payload buffer and the RGMII DDR output stage, and emits one byte per clock.

---
 rtl/eth_tx_framer.sv | 192 +++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble/SFD, MAC header, sequence number, buffered
// payload, zero pad to minimum size, and CRC-32 FCS, followed by the inter-frame gap.
`timescale 1ns/1ps
module eth_tx_framer #(
   parameter logic [47:0] DST_MAC   = 48'h5965239093d4,
   parameter logic [47:0] SRC_MAC   = 48'h666666666666,
   parameter logic [15:0] ETHERTYPE = 16'h1919,
   parameter int          MAX_LEN   = 1024,
   parameter int          AW        = 10,
   parameter int          RD_LAT    = 2,
   parameter int          IFG       = 12
) (
   input  logic          clk125,
   input  logic          rst,
   input  logic          start,
   input  logic [AW:0]   len,
   input  logic          bank,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   rd_addr,
   input  logic [7:0]    rd_data,
   output logic          txen,
   output logic [7:0]    txd,
   output logic [15:0]   seq,
   output logic [2:0]    dbg_state
);

   // Handshake: start is a one-cycle request that is honoured only while busy is
   // low; len and bank are captured on that same cycle and a start seen while
   // busy is high is discarded without touching any state.

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_HDR, S_PAY, S_PAD, S_FCS, S_IFG
   } state_t;

   localparam int             CW       = AW + 2;
   localparam logic [CW-1:0]  RD_OFF   = CW'(23 - RD_LAT);
   localparam logic [CW-1:0]  IFG_LAST = CW'(IFG - 1);
   localparam logic [AW:0]    MAX_P    = (AW+1)'(MAX_LEN);
   localparam logic [AW:0]    MIN_P    = (AW+1)'(44);

   state_t        state_q, state_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic [AW:0]   p_q;
   logic [CW-1:0] fcs_start_q;
   logic          bank_q;
   logic [15:0]   seq_frame_q;
   logic [15:0]   seq_r;
   logic [31:0]   crc_q, crc_n;
   logic [7:0]    txd_q, txd_n;
   logic          txen_q, txen_n;
   logic          done_q, done_n;
   logic [AW:0]   rd_addr_q;

   logic          accept;
   logic [AW:0]   p_clamp;
   logic [CW-1:0] fcs_start_n;
   logic [127:0]  hdr;
   logic [3:0]    hidx;
   logic [1:0]    fsel;
   logic [31:0]   crc_in;
   logic          crc_en;
   logic [CW-1:0] rd_k;
   logic          rd_en;

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign accept      = (state_q == S_IDLE) && start;
   assign p_clamp     = (len > MAX_P) ? MAX_P : len;
   assign fcs_start_n = CW'(24) + ((p_clamp > MIN_P) ? CW'(p_clamp) : CW'(44));

   // Header bytes 8..23 in transmit order, byte i at bits [8i+7:8i].
   assign hdr    = {seq_frame_q[15:8], seq_frame_q[7:0], ETHERTYPE[7:0], ETHERTYPE[15:8],
                    SRC_MAC, DST_MAC};
   assign hidx   = cnt_q[3:0] - 4'd8;
   assign fsel   = cnt_q[1:0] - fcs_start_q[1:0];
   assign crc_in = (cnt_q == CW'(8)) ? 32'hFFFFFFFF : crc_q;

   // Reads run RD_LAT cycles ahead of the byte that consumes them.
   assign rd_k  = cnt_q - RD_OFF;
   assign rd_en = (state_q != S_IDLE) && (state_q != S_IFG) &&
                  (cnt_q >= RD_OFF) && (rd_k < CW'(p_q));

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      txd_n   = 8'h00;
      txen_n  = 1'b0;
      done_n  = 1'b0;
      crc_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_n = S_PRE;
               cnt_n   = CW'(1);
               txd_n   = 8'h55;
               txen_n  = 1'b1;
            end
         end
         S_PRE: begin
            txen_n = 1'b1;
            txd_n  = (cnt_q == CW'(7)) ? 8'hD5 : 8'h55;
            cnt_n  = cnt_q + CW'(1);
            if (cnt_q == CW'(7)) state_n = S_HDR;
         end
         S_HDR: begin
            txen_n = 1'b1;
            txd_n  = hdr[{hidx, 3'b000} +: 8];
            crc_en = 1'b1;
            cnt_n  = cnt_q + CW'(1);
            if (cnt_q == CW'(23)) state_n = (p_q != '0) ? S_PAY : S_PAD;
         end
         S_PAY: begin
            txen_n = 1'b1;
            txd_n  = rd_data;
            crc_en = 1'b1;
            cnt_n  = cnt_q + CW'(1);
            if (cnt_q == CW'(23) + CW'(p_q))
               state_n = (cnt_q == fcs_start_q - CW'(1)) ? S_FCS : S_PAD;
         end
         S_PAD: begin
            txen_n = 1'b1;
            crc_en = 1'b1;
            cnt_n  = cnt_q + CW'(1);
            if (cnt_q == fcs_start_q - CW'(1)) state_n = S_FCS;
         end
         S_FCS: begin
            txen_n = 1'b1;
            txd_n  = ~crc_q[{fsel, 3'b000} +: 8];
            cnt_n  = cnt_q + CW'(1);
            if (fsel == 2'd3) begin
               state_n = S_IFG;
               cnt_n   = '0;
            end
         end
         S_IFG: begin
            done_n = (cnt_q == '0);
            cnt_n  = cnt_q + CW'(1);
            if (cnt_q == IFG_LAST) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      crc_n = crc_en ? crc_upd(crc_in, txd_n) : crc_q;
   end

   always_ff @(posedge clk125 or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         p_q         <= '0;
         fcs_start_q <= '0;
         bank_q      <= 1'b0;
         seq_frame_q <= '0;
         seq_r       <= '0;
         crc_q       <= '0;
         txd_q       <= '0;
         txen_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_addr_q   <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         crc_q   <= crc_n;
         txd_q   <= txd_n;
         txen_q  <= txen_n;
         done_q  <= done_n;
         if (accept) begin
            p_q         <= p_clamp;
            fcs_start_q <= fcs_start_n;
            bank_q      <= bank;
            seq_frame_q <= seq_r;
            seq_r       <= seq_r + 16'd1;
         end
         if (rd_en) rd_addr_q <= {bank_q, rd_k[AW-1:0]};
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign txen      = txen_q;
   assign txd       = txd_q;
   assign rd_addr   = rd_addr_q;
   assign seq       = seq_r;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: randomized and directed frames checked against a
// byte-level frame model with a software CRC-32.
`timescale 1ns/1ps
module tb_eth_tx_framer;
   localparam int AW   = 10;
   localparam int IFG  = 12;
   localparam int MAXL = 1024;

   // clock / reset / DUT
   logic          clk125 = 1'b0;
   logic          rst, start, bank;
   logic [AW:0]   len;
   logic          busy, done, txen;
   logic [AW:0]   rd_addr;
   logic [7:0]    rd_data, txd;
   logic [15:0]   seq;
   logic [2:0]    dbg_state;

   eth_tx_framer #(.MAX_LEN(MAXL), .AW(AW), .RD_LAT(2), .IFG(IFG)) dut (
      .clk125(clk125), .rst(rst), .start(start), .len(len), .bank(bank),
      .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
      .txen(txen), .txd(txd), .seq(seq), .dbg_state(dbg_state));

   always #4 clk125 = ~clk125;

   int cyc = 0;
   always @(posedge clk125) cyc <= cyc + 1;

   // payload buffer with two cycles of read latency
   logic [7:0] mem [0:2047];
   logic [7:0] d1;
   always @(posedge clk125) begin
      d1      <= mem[rd_addr];
      rd_data <= d1;
   end

   // monitor: collects frames, done pulses, rd_addr changes
   logic [7:0]  cur[$];
   logic [7:0]  rx_all[$];
   int          rx_len[$], rx_start[$], done_cyc[$], rd_cyc[$];
   logic [AW:0] rd_val[$];
   logic [AW:0] last_rd = '0;
   bit          in_frame = 0;
   int          cur_start = 0;
   int          idle_bad = 0;

   always @(negedge clk125) begin
      if (rst) begin
         cur.delete();
         in_frame = 0;
         last_rd  = rd_addr;
      end else begin
         if (txen) begin
            if (!in_frame) begin
               in_frame  = 1;
               cur_start = cyc;
            end
            cur.push_back(txd);
         end else begin
            if (txd !== 8'h00) idle_bad++;
            if (in_frame) begin
               in_frame = 0;
               rx_start.push_back(cur_start);
               rx_len.push_back(cur.size());
               foreach (cur[i]) rx_all.push_back(cur[i]);
               cur.delete();
            end
         end
         if (done) done_cyc.push_back(cyc);
         if (rd_addr !== last_rd) begin
            rd_cyc.push_back(cyc);
            rd_val.push_back(rd_addr);
            last_rd = rd_addr;
         end
      end
   end

   // scoreboard
   logic [7:0]  exp_q[$];
   int          exp_n_q[$], exp_t_q[$];
   logic [7:0]  last_rx[$];
   logic [15:0] model_seq;
   int          next_free, last_t;
   int          checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk125);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // expected frame, built byte by byte from the frame layout
   task automatic model_frame(input int l, input bit b, input int t);
      logic [7:0]  f[$];
      logic [47:0] dm, sm;
      logic [15:0] et;
      logic [31:0] c;
      int p, n;
      dm = 48'h5965239093d4;
      sm = 48'h666666666666;
      et = 16'h1919;
      p  = (l > MAXL) ? MAXL : l;
      for (int i = 0; i < 7; i++) f.push_back(8'h55);
      f.push_back(8'hD5);
      for (int i = 0; i < 6; i++) f.push_back(dm[8*i +: 8]);
      for (int i = 0; i < 6; i++) f.push_back(sm[8*i +: 8]);
      f.push_back(et[15:8]);
      f.push_back(et[7:0]);
      f.push_back(model_seq[7:0]);
      f.push_back(model_seq[15:8]);
      for (int k = 0; k < p; k++) f.push_back(mem[(b ? 1024 : 0) + k]);
      while (f.size() < 68) f.push_back(8'h00);
      c = 32'hFFFFFFFF;
      for (int i = 8; i < f.size(); i++) c = crc_ref(c, f[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
      n = 28 + ((p > 44) ? p : 44);
      exp_n_q.push_back(n);
      exp_t_q.push_back(t);
      foreach (f[i]) exp_q.push_back(f[i]);
      model_seq = model_seq + 16'd1;
      next_free = t + n + IFG;
   endtask

   // driver tasks
   task automatic drive_start(input int l, input bit b);
      start = 1'b1;
      len   = (AW+1)'(l);
      bank  = b;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input int l, input bit b);
      wait_until(next_free);
      last_t = cyc;
      model_frame(l, b, cyc);
      drive_start(l, b);
   endtask

   task automatic check_frame(input string tag);
      logic [7:0] ef[$];
      int tmo, n, t, n_rx, st, bad, first;
      logic [7:0] fa, fe;
      tmo = 0;
      n = exp_n_q.pop_front();
      t = exp_t_q.pop_front();
      for (int i = 0; i < n; i++) ef.push_back(exp_q.pop_front());
      while (rx_len.size() == 0 && tmo < 4000) begin
         tick();
         tmo++;
      end
      chk({tag, "_arrived"}, 32'(rx_len.size() > 0), 32'd1);
      if (rx_len.size() == 0) return;
      n_rx = rx_len.pop_front();
      st   = rx_start.pop_front();
      chk({tag, "_len"}, n_rx, n);
      chk({tag, "_txen_rise"}, st, t + 1);
      bad = 0; first = -1; fa = 0; fe = 0;
      last_rx.delete();
      for (int i = 0; i < n_rx; i++) begin
         last_rx.push_back(rx_all.pop_front());
         if (i < n && last_rx[i] !== ef[i]) begin
            if (first < 0) begin
               first = i; fa = last_rx[i]; fe = ef[i];
            end
            bad++;
         end
      end
      checks++;
      assert (bad === 0) else begin
         errors++;
         $error("FAIL %s_bytes: %0d wrong, first at byte %0d observed=%0h expected=%0h",
                tag, bad, first, fa, fe);
      end
      tmo = 0;
      while (done_cyc.size() == 0 && tmo < 4) begin
         tick();
         tmo++;
      end
      chk({tag, "_done"}, (done_cyc.size() > 0) ? done_cyc.pop_front() : -1, t + n + 1);
   endtask

   initial begin
      int t, t0, bad;
      logic [31:0] c;
      rst = 1'b1; start = 1'b0; len = '0; bank = 1'b0;
      model_seq = 16'd0; next_free = 0; last_t = 0;
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom_range(0, 255));
      repeat (3) tick();

      // reset values
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_txen", txen, 0);
      chk("rst_txd", txd, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_seq", seq, 0);
      rst = 1'b0;
      tick();
      next_free = cyc;

      // minimum frame
      send(0, 0);
      t = last_t;
      check_frame("min");
      chk("min_no_reads", rd_cyc.size(), 0);
      c = 32'hFFFFFFFF;
      for (int i = 8; i < last_rx.size(); i++) c = crc_ref(c, last_rx[i]);
      chk("min_residue", c, 32'hDEBB20E3);
      chk("min_seq_next", seq, 1);
      wait_until(t + 72 + IFG - 1);
      chk("min_busy_last", busy, 1);
      tick();
      chk("min_busy_clear", busy, 0);

      // full frame, bank 1, counting payload
      for (int k = 0; k < 1024; k++) mem[1024 + k] = 8'(k);
      rd_cyc.delete(); rd_val.delete();
      send(1024, 1);
      t = last_t;
      check_frame("full");
      chk("full_rd_count", rd_cyc.size(), 1024);
      bad = 0;
      for (int k = 0; k < rd_cyc.size(); k++)
         if (rd_cyc[k] != t + 22 + k || rd_val[k] !== (AW+1)'(1024 + k)) bad++;
      chk("full_rd_timing", bad, 0);

      // clamp and pad boundaries
      send(2000, 0); check_frame("clamp");
      send(43, 1);   check_frame("pad43");
      send(44, 0);   check_frame("pad44");
      send(45, 1);   check_frame("len45");

      // random lengths and banks
      for (int i = 0; i < 4; i++) begin
         send($urandom_range(1, 300), 1'($urandom_range(0, 1)));
         check_frame("rand");
      end

      // start while busy is dropped
      send(60, 0);
      t = last_t;
      wait_until(t + 30);
      drive_start(10, 1);
      check_frame("busy_ign");
      chk("busy_ign_seq", seq, model_seq);
      send(20, 1); check_frame("after_ign");

      // back-to-back with start held high
      wait_until(next_free);
      t0 = cyc;
      start = 1'b1; len = (AW+1)'(100); bank = 1'b0;
      for (int i = 0; i < 3; i++) model_frame(100, 0, t0 + i * 140);
      wait_until(t0 + 281);
      start = 1'b0;
      chk("b2b_gap", (rx_start.size() >= 2) ? rx_start[1] - rx_start[0] - 128 : -1, IFG);
      for (int i = 0; i < 3; i++) check_frame("b2b");

      // reset in the middle of a frame
      wait_until(next_free);
      t = cyc;
      drive_start(600, 1);
      wait_until(t + 501);
      chk("rstmid_pre_txen", txen, 1);
      rst = 1'b1;
      #1;
      chk("rstmid_txen", txen, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_seq", seq, 0);
      chk("rstmid_txd", txd, 0);
      chk("rstmid_done", done, 0);
      chk("rstmid_rd_addr", rd_addr, 0);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      model_seq = 16'd0;
      next_free = cyc;
      send(46, 0); check_frame("post_rst");

      // sequence wrap from a preloaded value
      wait_until(next_free);
      force dut.seq_r = 16'hFFFE;
      tick();
      release dut.seq_r;
      chk("wrap_preload", seq, 16'hFFFE);
      model_seq = 16'hFFFE;
      send(10, 1); check_frame("wrap0");
      send(50, 0); check_frame("wrap1");
      chk("wrap_seq", seq, 0);
      send(5, 0);  check_frame("wrap2");

      chk("txd_idle_zero", idle_bad, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
